// File: rtl/kronos_types_pkg.sv
// Kronos shared types for the EX/WB boundary and the write-back/LSU stage.
//   mem_size_t   : access size carried with loads and stores
//   trap_cause_t : cause code reported alongside trap
//   wb_state_t   : write-back / LSU sequencer states
//   pipeEXWB_t   : EX->WB payload (ALU result, branch info, memory op info)
package kronos_types;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        TRAP_ILLEGAL  = 2'd0,
        TRAP_MISALIGN = 2'd1,
        TRAP_TIMEOUT  = 2'd2
    } trap_cause_t;

    typedef enum logic [1:0] {
        WRITE = 2'd0,
        MEM_A = 2'd1,
        MEM_B = 2'd2,
        CATCH = 2'd3
    } wb_state_t;

    // result1: rd data, or memory address for ld/st
    // result2: branch target, or store data for st
    typedef struct packed {
        logic [31:0] result1;
        logic [31:0] result2;
        logic [4:0]  rd;
        logic        rd_write;
        logic        branch;
        logic        branch_cond;
        logic        is_illegal;
        logic        ld;
        logic        st;
        mem_size_t   mem_size;
        logic        ld_sign;
    } pipeEXWB_t;

    // Byte-lane mask of an access of the given size starting at lane 0.
    function automatic logic [3:0] size_mask(input mem_size_t size);
        case (size)
            BYTE:    size_mask = 4'b0001;
            HALF:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/kronos_lsu_align.sv
// Byte-lane arithmetic for the load/store unit (purely combinational).
//   off, size, sign : byte offset within the word, access size, load sign-extend
//   st_data         : store data, lane 0 aligned
//   ld_data         : {hi, lo} raw bus words covering the access
//   m8              : byte enables over the two-word window {hi lanes, lo lanes}
//   st_data64       : store data shifted into its lanes across the window
//   ld_result       : load data shifted down, truncated and extended
module kronos_lsu_align
    import kronos_types::*;
(
    input  logic [1:0]  off,
    input  mem_size_t   size,
    input  logic        sign,
    input  logic [31:0] st_data,
    input  logic [63:0] ld_data,
    output logic [7:0]  m8,
    output logic [63:0] st_data64,
    output logic [31:0] ld_result
);

    logic [5:0]  bit_off;
    logic [31:0] ld_word;

    assign bit_off   = {off, 3'b000};
    assign m8        = {4'b0000, size_mask(size)} << off;
    assign st_data64 = {32'b0, st_data} << bit_off;
    assign ld_word   = 32'(ld_data >> bit_off);

    always_comb begin
        case (size)
            BYTE:    ld_result = {{24{sign & ld_word[7]}},  ld_word[7:0]};
            HALF:    ld_result = {{16{sign & ld_word[15]}}, ld_word[15:0]};
            default: ld_result = ld_word;
        endcase
    end

endmodule

// File: rtl/kronos_wb_lsu.sv
// Kronos write-back stage with load/store unit.
// Retires ALU results and branches in one cycle, sequences loads/stores on a
// req/ack data bus (one bus cycle aligned, two for accesses straddling a word
// when MISALIGN_SPLIT=1), and traps on illegal instructions, misaligned
// accesses (MISALIGN_SPLIT=0) or bus timeout (BUS_TIMEOUT != 0).
// Ports:
//   clk, rstz                      clock, async active-low reset
//   execute, pipe_in_vld           EX/WB payload (held stable until retire)
//   pipe_in_rdy                    instruction retires this cycle
//   regwr_data/sel/en              register file write port
//   branch_target, branch          branch redirect
//   data_addr/wr_data/mask/wr_en   data bus request fields
//   data_req, data_rd_data, data_ack  data bus handshake
//   trap, trap_cause               one-cycle trap pulse and its cause
module kronos_wb_lsu
    import kronos_types::*;
#(
    parameter bit          MISALIGN_SPLIT = 1'b1,
    parameter int unsigned BUS_TIMEOUT    = 0
)(
    input  logic        clk,
    input  logic        rstz,
    input  pipeEXWB_t   execute,
    input  logic        pipe_in_vld,
    output logic        pipe_in_rdy,
    output logic [31:0] regwr_data,
    output logic [4:0]  regwr_sel,
    output logic        regwr_en,
    output logic [31:0] branch_target,
    output logic        branch,
    output logic [31:0] data_addr,
    output logic [31:0] data_wr_data,
    output logic [3:0]  data_mask,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic [31:0] data_rd_data,
    input  logic        data_ack,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    wb_state_t   state, state_next;
    logic [TW-1:0] wait_cnt;
    logic [31:0] lo_q;
    logic        capture_lo;
    trap_cause_t cause;

    logic [1:0]  off;
    logic [31:0] word_addr;
    logic [7:0]  m8;
    logic [63:0] st_data64;
    logic [63:0] ld_data;
    logic [31:0] ld_result;
    logic        is_mem, split, misaligned, timeout;

    assign off       = execute.result1[1:0];
    assign word_addr = {execute.result1[31:2], 2'b00};
    assign is_mem    = execute.ld | execute.st;
    assign split     = |m8[7:4];
    assign misaligned = ((execute.mem_size == HALF) & off[0]) |
                        ((execute.mem_size == WORD) & (off != 2'b00));

    // Timeout fires in the BUS_TIMEOUT-th cycle spent waiting in a bus state;
    // an ack arriving in that same cycle still wins.
    assign timeout = (BUS_TIMEOUT != 0) && (wait_cnt == TW'(BUS_TIMEOUT - 1));

    // Non-split loads see only the current bus word; the second half of a
    // split load combines with the word captured in MEM_A.
    assign ld_data = (state == MEM_B) ? {data_rd_data, lo_q} : {32'b0, data_rd_data};

    kronos_lsu_align u_align (
        .off       (off),
        .size      (execute.mem_size),
        .sign      (execute.ld_sign),
        .st_data   (execute.result2),
        .ld_data   (ld_data),
        .m8        (m8),
        .st_data64 (st_data64),
        .ld_result (ld_result)
    );

    assign regwr_sel     = execute.rd;
    assign branch_target = execute.result2;
    assign trap_cause    = cause;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state    <= WRITE;
            wait_cnt <= '0;
            lo_q     <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == MEM_A || state == MEM_B)
                wait_cnt <= wait_cnt + 1'b1;
            if (capture_lo)
                lo_q <= data_rd_data;
        end
    end

    always_comb begin
        state_next   = state;
        pipe_in_rdy  = 1'b0;
        regwr_en     = 1'b0;
        regwr_data   = '0;
        branch       = 1'b0;
        data_req     = 1'b0;
        data_addr    = '0;
        data_mask    = '0;
        data_wr_data = '0;
        data_wr_en   = 1'b0;
        trap         = 1'b0;
        cause        = TRAP_ILLEGAL;
        capture_lo   = 1'b0;

        case (state)
            WRITE: begin
                if (pipe_in_vld) begin
                    if (execute.is_illegal) begin
                        trap       = 1'b1;
                        cause      = TRAP_ILLEGAL;
                        state_next = CATCH;
                    end else if (is_mem) begin
                        if (!MISALIGN_SPLIT && misaligned) begin
                            trap       = 1'b1;
                            cause      = TRAP_MISALIGN;
                            state_next = CATCH;
                        end else begin
                            state_next = MEM_A;
                        end
                    end else begin
                        pipe_in_rdy = 1'b1;
                        regwr_en    = execute.rd_write;
                        regwr_data  = execute.result1;
                        branch      = execute.branch |
                                      (execute.branch_cond & execute.result1[0]);
                    end
                end
            end

            MEM_A: begin
                data_req     = 1'b1;
                data_addr    = word_addr;
                data_mask    = m8[3:0];
                data_wr_data = st_data64[31:0];
                data_wr_en   = execute.st;
                if (data_ack) begin
                    if (split) begin
                        capture_lo = 1'b1;
                        state_next = MEM_B;
                    end else begin
                        pipe_in_rdy = 1'b1;
                        regwr_en    = execute.ld & execute.rd_write;
                        regwr_data  = execute.ld ? ld_result : '0;
                        state_next  = WRITE;
                    end
                end else if (timeout) begin
                    trap       = 1'b1;
                    cause      = TRAP_TIMEOUT;
                    state_next = CATCH;
                end
            end

            MEM_B: begin
                data_req     = 1'b1;
                data_addr    = word_addr + 32'd4;
                data_mask    = m8[7:4];
                data_wr_data = st_data64[63:32];
                data_wr_en   = execute.st;
                if (data_ack) begin
                    pipe_in_rdy = 1'b1;
                    regwr_en    = execute.ld & execute.rd_write;
                    regwr_data  = execute.ld ? ld_result : '0;
                    state_next  = WRITE;
                end else if (timeout) begin
                    trap       = 1'b1;
                    cause      = TRAP_TIMEOUT;
                    state_next = CATCH;
                end
            end

            CATCH: ;  // terminal until reset

            default: state_next = WRITE;
        endcase
    end

endmodule

// File: tb/tb_kronos_wb_lsu.sv
// Directed bench for kronos_wb_lsu. dut_a splits misaligned accesses and times
// out after 4 cycles; dut_b traps misaligned accesses and waits forever.
// Both share the stimulus.
module tb_kronos_wb_lsu;
    import kronos_types::*;

    logic        clk, rstz;
    pipeEXWB_t   execute;
    logic        pipe_in_vld, data_ack;
    logic [31:0] data_rd_data;

    logic        rdy_a, regwr_en_a, branch_a, wr_en_a, req_a, trap_a;
    logic [31:0] regwr_data_a, target_a, addr_a, wdata_a;
    logic [4:0]  sel_a;
    logic [3:0]  mask_a;
    logic [1:0]  cause_a;

    logic        rdy_b, regwr_en_b, branch_b, wr_en_b, req_b, trap_b;
    logic [31:0] regwr_data_b, target_b, addr_b, wdata_b;
    logic [4:0]  sel_b;
    logic [3:0]  mask_b;
    logic [1:0]  cause_b;

    int n_chk  = 0;
    int n_fail = 0;

    kronos_wb_lsu #(.MISALIGN_SPLIT(1'b1), .BUS_TIMEOUT(4)) dut_a (
        .clk(clk), .rstz(rstz), .execute(execute), .pipe_in_vld(pipe_in_vld),
        .pipe_in_rdy(rdy_a), .regwr_data(regwr_data_a), .regwr_sel(sel_a),
        .regwr_en(regwr_en_a), .branch_target(target_a), .branch(branch_a),
        .data_addr(addr_a), .data_wr_data(wdata_a), .data_mask(mask_a),
        .data_wr_en(wr_en_a), .data_req(req_a), .data_rd_data(data_rd_data),
        .data_ack(data_ack), .trap(trap_a), .trap_cause(cause_a)
    );

    kronos_wb_lsu #(.MISALIGN_SPLIT(1'b0), .BUS_TIMEOUT(0)) dut_b (
        .clk(clk), .rstz(rstz), .execute(execute), .pipe_in_vld(pipe_in_vld),
        .pipe_in_rdy(rdy_b), .regwr_data(regwr_data_b), .regwr_sel(sel_b),
        .regwr_en(regwr_en_b), .branch_target(target_b), .branch(branch_b),
        .data_addr(addr_b), .data_wr_data(wdata_b), .data_mask(mask_b),
        .data_wr_en(wr_en_b), .data_req(req_b), .data_rd_data(data_rd_data),
        .data_ack(data_ack), .trap(trap_b), .trap_cause(cause_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic pipeEXWB_t mk(input logic [31:0] r1, input logic [31:0] r2,
                                     input logic [4:0] rd, input logic rdw,
                                     input logic br, input logic brc, input logic ill,
                                     input logic ld, input logic st,
                                     input mem_size_t sz, input logic sgn);
        pipeEXWB_t p;
        p.result1 = r1;  p.result2 = r2;  p.rd = rd;  p.rd_write = rdw;
        p.branch = br;   p.branch_cond = brc;  p.is_illegal = ill;
        p.ld = ld;       p.st = st;  p.mem_size = sz;  p.ld_sign = sgn;
        return p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstz = 1'b0; pipe_in_vld = 1'b0; data_ack = 1'b0;
        @(negedge clk);
        rstz = 1'b1;
    endtask

    // Table record: payload, bus read data, expected bus request (memory ops)
    // and expected retire outputs.
    typedef struct {
        string       name;
        pipeEXWB_t   ex;
        logic        mem;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        we;
        logic [31:0] wdata;
        logic        en;
        logic [31:0] data;
        logic        br;
    } vec_t;

    vec_t vecs[10];

    initial begin
        rstz = 1'b0; execute = '0; pipe_in_vld = 1'b0;
        data_ack = 1'b0; data_rd_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdy",     rdy_a,        0);
        chk("rst_regwr_en",regwr_en_a,   0);
        chk("rst_regwr_d", regwr_data_a, 0);
        chk("rst_branch",  branch_a,     0);
        chk("rst_req",     req_a,        0);
        chk("rst_mask",    mask_a,       0);
        chk("rst_trap",    trap_a,       0);
        chk("rst_cause",   cause_a,      0);
        rstz = 1'b1;

        //           name        ex                                                                  mem rd            addr     mask     we wdata          en data          br
        vecs[0] = '{"alu",       mk(32'h1234, 32'h0,   5'd5, 1,0,0,0, 0,0, WORD, 0),               0, 32'h0,        32'h0,   4'b0000, 0, 32'h0,         1, 32'h1234,     0};
        vecs[1] = '{"bcond_t",   mk(32'h1,    32'h80,  5'd0, 0,0,1,0, 0,0, WORD, 0),               0, 32'h0,        32'h0,   4'b0000, 0, 32'h0,         0, 32'h1,        1};
        vecs[2] = '{"bcond_nt",  mk(32'h0,    32'h80,  5'd0, 0,0,1,0, 0,0, WORD, 0),               0, 32'h0,        32'h0,   4'b0000, 0, 32'h0,         0, 32'h0,        0};
        vecs[3] = '{"jal",       mk(32'h104,  32'h400, 5'd1, 1,1,0,0, 0,0, WORD, 0),               0, 32'h0,        32'h0,   4'b0000, 0, 32'h0,         1, 32'h104,      1};
        vecs[4] = '{"lb_s",      mk(32'h103,  32'h0,   5'd7, 1,0,0,0, 1,0, BYTE, 1),               1, 32'h80FFFFFF, 32'h100, 4'b1000, 0, 32'h0,         1, 32'hFFFFFF80, 0};
        vecs[5] = '{"lb_u",      mk(32'h103,  32'h0,   5'd7, 1,0,0,0, 1,0, BYTE, 0),               1, 32'h80FFFFFF, 32'h100, 4'b1000, 0, 32'h0,         1, 32'h00000080, 0};
        vecs[6] = '{"lh_s",      mk(32'h102,  32'h0,   5'd8, 1,0,0,0, 1,0, HALF, 1),               1, 32'h80011234, 32'h100, 4'b1100, 0, 32'h0,         1, 32'hFFFF8001, 0};
        vecs[7] = '{"lh_u",      mk(32'h2,    32'h0,   5'd8, 1,0,0,0, 1,0, HALF, 0),               1, 32'h80011234, 32'h0,   4'b1100, 0, 32'h0,         1, 32'h00008001, 0};
        vecs[8] = '{"sw",        mk(32'h300,  32'hAABBCCDD, 5'd2, 1,0,0,0, 0,1, WORD, 0),          1, 32'h0,        32'h300, 4'b1111, 1, 32'hAABBCCDD, 0, 32'h0,        0};
        vecs[9] = '{"sb",        mk(32'h301,  32'h000000EE, 5'd2, 0,0,0,0, 0,1, BYTE, 0),          1, 32'h0,        32'h300, 4'b0010, 1, 32'h0000EE00, 0, 32'h0,        0};

        foreach (vecs[i]) begin
            @(negedge clk);
            execute = vecs[i].ex; pipe_in_vld = 1'b1; data_ack = 1'b0;
            #1;
            if (!vecs[i].mem) begin
                chk({vecs[i].name, "_rdy"},    rdy_a,        1);
                chk({vecs[i].name, "_en"},     regwr_en_a,   vecs[i].en);
                chk({vecs[i].name, "_data"},   regwr_data_a, vecs[i].data);
                chk({vecs[i].name, "_sel"},    sel_a,        vecs[i].ex.rd);
                chk({vecs[i].name, "_branch"}, branch_a,     vecs[i].br);
                chk({vecs[i].name, "_target"}, target_a,     vecs[i].ex.result2);
                chk({vecs[i].name, "_req"},    req_a,        0);
            end else begin
                chk({vecs[i].name, "_rdy0"},   rdy_a,        0);
                @(negedge clk);
                #1;
                chk({vecs[i].name, "_req"},    req_a,        1);
                chk({vecs[i].name, "_addr"},   addr_a,       vecs[i].addr);
                chk({vecs[i].name, "_mask"},   mask_a,       vecs[i].mask);
                chk({vecs[i].name, "_we"},     wr_en_a,      vecs[i].we);
                chk({vecs[i].name, "_wdata"},  wdata_a,      vecs[i].wdata);
                data_ack = 1'b1; data_rd_data = vecs[i].rd;
                #1;
                chk({vecs[i].name, "_rdy"},    rdy_a,        1);
                chk({vecs[i].name, "_en"},     regwr_en_a,   vecs[i].en);
                if (vecs[i].en)
                    chk({vecs[i].name, "_data"}, regwr_data_a, vecs[i].data);
                @(negedge clk);
                data_ack = 1'b0; pipe_in_vld = 1'b0;
            end
        end

        // Split word store at 0x202
        do_reset();
        @(negedge clk);
        execute = mk(32'h202, 32'hAABBCCDD, 5'd0, 0,0,0,0, 0,1, WORD, 0);
        pipe_in_vld = 1'b1;
        @(negedge clk); #1;
        chk("sws_a_addr",  addr_a,  32'h200);
        chk("sws_a_mask",  mask_a,  4'b1100);
        chk("sws_a_wdata", wdata_a, 32'hCCDD0000);
        chk("sws_a_we",    wr_en_a, 1);
        data_ack = 1'b1; #1;
        chk("sws_a_rdy",   rdy_a,   0);
        @(negedge clk); data_ack = 1'b0; #1;
        chk("sws_b_req",   req_a,   1);
        chk("sws_b_addr",  addr_a,  32'h204);
        chk("sws_b_mask",  mask_a,  4'b0011);
        chk("sws_b_wdata", wdata_a, 32'h0000AABB);
        chk("sws_b_rdy0",  rdy_a,   0);
        data_ack = 1'b1; #1;
        chk("sws_b_rdy",   rdy_a,   1);
        chk("sws_b_en",    regwr_en_a, 0);
        @(negedge clk); data_ack = 1'b0; pipe_in_vld = 1'b0; #1;
        chk("sws_idle_req", req_a, 0);
        chk("sws_idle_rdy", rdy_a, 0);

        // Split signed half load at 0x3
        @(negedge clk);
        execute = mk(32'h3, 32'h0, 5'd9, 1,0,0,0, 1,0, HALF, 1);
        pipe_in_vld = 1'b1;
        @(negedge clk); #1;
        chk("slh_a_addr", addr_a, 32'h0);
        chk("slh_a_mask", mask_a, 4'b1000);
        data_ack = 1'b1; data_rd_data = 32'h34000000; #1;
        chk("slh_a_rdy",  rdy_a,  0);
        @(negedge clk); data_ack = 1'b0; #1;
        chk("slh_b_addr", addr_a, 32'h4);
        chk("slh_b_mask", mask_a, 4'b0001);
        data_ack = 1'b1; data_rd_data = 32'h000000F2; #1;
        chk("slh_b_rdy",  rdy_a,  1);
        chk("slh_b_en",   regwr_en_a, 1);
        chk("slh_b_data", regwr_data_a, 32'hFFFFF234);
        @(negedge clk); data_ack = 1'b0; pipe_in_vld = 1'b0;

        // Misaligned half load traps in dut_b, then stays in CATCH
        do_reset();
        @(negedge clk);
        execute = mk(32'h3, 32'h0, 5'd9, 1,0,0,0, 1,0, HALF, 1);
        pipe_in_vld = 1'b1; #1;
        chk("mis_trap",  trap_b,  1);
        chk("mis_cause", cause_b, 1);
        chk("mis_req",   req_b,   0);
        chk("mis_rdy",   rdy_b,   0);
        @(negedge clk); #1;
        chk("mis_trap_pulse", trap_b, 0);
        chk("mis_catch_req",  req_b,  0);
        execute = mk(32'h55, 32'h0, 5'd3, 1,0,0,0, 0,0, WORD, 0); #1;
        chk("mis_catch_rdy",  rdy_b,  0);
        chk("mis_catch_en",   regwr_en_b, 0);

        // Illegal instruction in dut_a
        do_reset();
        @(negedge clk);
        execute = mk(32'h55, 32'h0, 5'd3, 1,0,0,1, 0,0, WORD, 0);
        pipe_in_vld = 1'b1; #1;
        chk("ill_trap",  trap_a,     1);
        chk("ill_cause", cause_a,    0);
        chk("ill_rdy",   rdy_a,      0);
        chk("ill_en",    regwr_en_a, 0);
        @(negedge clk);
        execute = mk(32'h55, 32'h0, 5'd3, 1,0,0,0, 0,0, WORD, 0); #1;
        chk("ill_trap_pulse", trap_a, 0);
        chk("ill_catch_rdy",  rdy_a,  0);

        // Bus timeout in dut_a: trap on the 4th wait cycle
        do_reset();
        @(negedge clk);
        execute = mk(32'h10, 32'h0, 5'd4, 1,0,0,0, 1,0, WORD, 0);
        pipe_in_vld = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1;
            chk($sformatf("to_req_%0d", i),  req_a,  1);
            chk($sformatf("to_trap_%0d", i), trap_a, (i == 4) ? 1 : 0);
            if (i == 4) chk("to_cause", cause_a, 2);
        end
        @(negedge clk); #1;
        chk("to_req_drop", req_a,  0);
        chk("to_trap_end", trap_a, 0);

        // Reset asserted during MEM_B
        do_reset();
        @(negedge clk);
        execute = mk(32'h202, 32'hAABBCCDD, 5'd0, 0,0,0,0, 0,1, WORD, 0);
        pipe_in_vld = 1'b1;
        @(negedge clk); data_ack = 1'b1;
        @(negedge clk); data_ack = 1'b0; #1;
        chk("rmb_req", req_a, 1);
        chk("rmb_addr", addr_a, 32'h204);
        rstz = 1'b0; #1;
        chk("rmb_req_async", req_a, 0);
        chk("rmb_rdy",       rdy_a, 0);
        @(negedge clk);
        rstz = 1'b1; pipe_in_vld = 1'b0; #1;
        chk("rmb_rel_req", req_a, 0);
        @(negedge clk);
        execute = mk(32'h55, 32'h0, 5'd3, 1,0,0,0, 0,0, WORD, 0);
        pipe_in_vld = 1'b1; #1;
        chk("rmb_write_rdy",  rdy_a,        1);
        chk("rmb_write_data", regwr_data_a, 32'h55);
        @(negedge clk); pipe_in_vld = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/kronos_wb_lsu.md
Name: kronos_wb_lsu

Overview:
- Final Kronos pipeline stage, successor to the single-cycle write-back stage.
- Keeps register write-back, unconditional/conditional branch and illegal-instruction catch.
- Adds a load/store unit on a request/ack data bus: byte/half/word sizes, sign extension, byte-lane masks.
- Misaligned accesses are either split into two word-aligned bus cycles or trapped, selected by parameter.

Parameters:
- MISALIGN_SPLIT, 1: 1 = split misaligned accesses into two bus cycles; 0 = trap them.
- BUS_TIMEOUT, 0: ack wait limit in cycles; 0 = wait forever; otherwise trap after BUS_TIMEOUT cycles without ack.

Ports:
- clk  in  1  clock
- rstz  in  1  reset
- execute  in  pipeEXWB_t  EX/WB payload. Existing fields plus ld, st, mem_size[1:0] (0 byte, 1 half, 2 word), ld_sign. result1 = rd data or memory address. result2 = branch target or store data.
- pipe_in_vld  in  1  payload valid
- pipe_in_rdy  out  1  instruction retires this cycle
- regwr_data  out  32  register write data
- regwr_sel  out  5  register write select
- regwr_en  out  1  register write enable
- branch_target  out  32  branch PC
- branch  out  1  branch taken
- data_addr  out  32  word-aligned bus address
- data_wr_data  out  32  store data, lane-aligned
- data_mask  out  4  byte-lane enables
- data_wr_en  out  1  store when 1, load when 0
- data_req  out  1  bus request
- data_rd_data  in  32  load data, valid with ack
- data_ack  in  1  bus access complete
- trap  out  1  one-cycle pulse on illegal instruction, misaligned access (MISALIGN_SPLIT=0) or timeout
- trap_cause  out  2  0 illegal, 1 misaligned, 2 timeout

Behaviour:
- Reset: rstz is asynchronous, active-low; clock is clk. All outputs, state, captured low word and timeout counter reset to 0. State = WRITE.
- Reset mid-operation: data_req drops asynchronously; the in-flight access is abandoned with no retire.
- States: WRITE, MEM_A, MEM_B, CATCH.
- Upstream holds execute stable while pipe_in_rdy = 0; the block does not register the payload.
- WRITE with vld:
  - illegal -> CATCH; trap pulses, cause 0.
  - ld or st -> MEM_A; rdy = 0.
  - Otherwise retire in the same cycle: rdy = 1, regwr_en = rd_write, branch = branch | (branch_cond & result1[0]).
- Address split:
  - off = result1[1:0].
  - smask = 0001/0011/1111 by size.
  - m8 = {4'b0, smask} << off.
  - split = |m8[7:4].
- Misaligned trap (MISALIGN_SPLIT=0): if (half & off[0]) or (word & off != 0), the WRITE -> MEM_A transition instead goes to CATCH; trap pulses, cause 1, no bus access.
- MEM_A:
  - data_req = 1, data_addr = {result1[31:2], 2'b00}, data_mask = m8[3:0], data_wr_en = st.
  - data_wr_data = low word of ({32'b0, result2} << 8*off).
  - On ack: if split, capture data_rd_data as lo and go to MEM_B; else retire.
- MEM_B:
  - data_addr = {result1[31:2], 2'b00} + 4, data_mask = m8[7:4], data_wr_data = high word of the same shift.
  - On ack: retire.
- Retire from memory:
  - rdy = 1 for one cycle; next state WRITE.
  - Load: regwr_en = rd_write; regwr_data = ({hi, lo} >> 8*off), truncated to size, then sign-extended if ld_sign else zero-extended. hi = data_rd_data in MEM_B; for non-split accesses, lo = data_rd_data and hi = 0.
  - Store: regwr_en = 0.
- regwr_sel = execute.rd, branch_target = result2 at all times.
- Latency: ALU/branch 1 cycle; aligned memory op >= 2 cycles; split memory op >= 3 cycles.
- Timeout: counter clears on state entry. If BUS_TIMEOUT != 0 and the counter reaches BUS_TIMEOUT in MEM_A or MEM_B -> CATCH, trap cause 2, data_req drops.
- data_ack outside MEM_A/MEM_B is ignored.
- CATCH is terminal until reset: rdy = 0, no bus requests, no writes.

Decomposition:
- kronos_types gains: mem_size enum (BYTE, HALF, WORD), trap_cause enum, and the ld/st/mem_size/ld_sign fields in pipeEXWB_t.
- One sub-module, kronos_lsu_align: purely combinational.
  - Inputs: off, size, sign, store data, {hi, lo}.
  - Outputs: m8, the 64-bit shifted store data, and the formatted load result.
  - Isolates all byte-lane arithmetic from the sequencer.

Test Plan:
- ALU op, rd = 5, result1 = 0x1234, rd_write = 1 -> same cycle: rdy = 1, regwr_en = 1, regwr_data = 0x1234; no data_req.
- branch_cond with result1 = 1, result2 = 0x80 -> branch = 1, branch_target = 0x80. Repeat with result1 = 0 -> branch = 0.
- Signed byte load, addr 0x103, bus returns 0x80FFFFFF -> data_addr = 0x100, mask = 1000, regwr_data = 0xFFFFFF80. Same access unsigned -> 0x00000080.
- Word store 0xAABBCCDD at addr 0x202, MISALIGN_SPLIT = 1:
  - Access 1: addr 0x200, mask 1100, wr_data 0xCCDD0000.
  - Access 2: addr 0x204, mask 0011, wr_data 0x0000AABB.
  - rdy pulses after the second ack.
- Half load at 0x3 with MISALIGN_SPLIT = 0 -> no data_req, trap = 1 with cause 1, then stuck in CATCH. An illegal instruction -> trap cause 0, rdy stays 0.
- BUS_TIMEOUT = 4, ack never arrives -> trap cause 2 on the 4th wait cycle. Separately, assert rstz low during MEM_B -> data_req = 0 immediately and state = WRITE after reset release.
